gray_rd_arb: RTL and testbench
==============================

GRAY_RD_ARB -- requirements
Module: gray_rd_arb

Interface
REQ-001 Parameters SHALL be ADDR_W=14 (gray image address width, 128x128 frame), DATA_W=8 (gray pixel width), BURST_MAX=9 (grants per ownership burst, one 3x3 LBP window).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req0  in  1  port 0 read request; addr0 SHALL be held stable while req0=1 and gnt0=0.
REQ-005 addr0  in  ADDR_W  port 0 read address.
REQ-006 gnt0  out  1  port 0 request accepted this cycle (combinational).
REQ-007 rdata0  out  DATA_W  port 0 read data, meaningful only when rvalid0=1.
REQ-008 rvalid0  out  1  port 0 read data valid, one cycle per granted read.
REQ-009 req1, addr1, gnt1, rdata1, rvalid1 SHALL mirror REQ-004..REQ-008 for port 1.
REQ-010 gray_req  out  1  memory read strobe, registered.
REQ-011 gray_addr  out  ADDR_W  memory read address, registered.
REQ-012 gray_data  in  DATA_W  memory read data, valid the cycle after gray_req=1.
REQ-013 busy  out  1  registered; 1 when state is not IDLE.

Function
REQ-014 States SHALL be IDLE, OWN0 and OWN1; registers: last (last port granted), cnt (4-bit grant count within the current burst).
REQ-015 At most one of gnt0/gnt1 SHALL be 1 in any cycle; a grant SHALL only be given to a port whose req is 1.
REQ-016 IDLE: if exactly one req is high, that port SHALL be granted; if both are high, the port != last SHALL be granted; the next state SHALL be OWN of the granted port with cnt=1.
REQ-017 OWNk, req_k=1 and cnt<BURST_MAX: grant k, cnt SHALL increment.
REQ-018 OWNk, other port requesting and (req_k=0 or cnt=BURST_MAX): grant the other port; the next state SHALL be OWN of the other port with cnt=1 (no bubble cycle).
REQ-019 OWNk, req_k=1, cnt=BURST_MAX, other port idle: grant k and cnt SHALL be set to 1.
REQ-020 OWNk, no request from either port: no grant; next state SHALL be IDLE; last SHALL be left unchanged.
REQ-021 last SHALL update to the granted port on every grant.
REQ-022 On each edge at which gnt_k=1, gray_req SHALL be set to 1 and gray_addr to addr_k; with no grant, gray_req SHALL be set to 0 and gray_addr SHALL hold its value.
REQ-023 Return: a 1-bit port tag SHALL be registered alongside gray_req; on the cycle after gray_req=1, rdata_tag=gray_data and rvalid_tag=1, and the other rvalid SHALL be 0.
REQ-024 Latency from gnt_k to rvalid_k SHALL be exactly 2 cycles; sustained throughput SHALL be 1 read/cycle.
REQ-025 rdata0 and rdata1 SHALL both be driven from gray_data; only the matching rvalid qualifies the data.
REQ-026 Address width SHALL be passed through unmodified; the block performs no address arithmetic.

Reset
REQ-027 While reset=0: state=IDLE, cnt=0, last=1 (port 0 wins the first tie), gray_req=0, gray_addr=0, busy=0, rvalid0=0, rvalid1=0, tag=0.
REQ-028 Reset mid-transfer SHALL discard in-flight reads; no rvalid SHALL be asserted for reads issued before reset.
REQ-029 gnt0/gnt1 SHALL be 0 while reset=0 regardless of req.

Structure
REQ-030 Package lbp_pkg SHALL hold ADDR_W, DATA_W, BURST_MAX and the state enum (IDLE, OWN0, OWN1).
REQ-031 Sub-module rr_pick2 (2-way round-robin choice from req0, req1 and last) SHALL be instantiated once; everything else SHALL be flat.

Verification
REQ-032 Single port: req0=1 with addr0=129 for 3 cycles, req1=0 -> gnt0 on 3 cycles, gray_addr=129, rvalid0 two cycles after each gnt0; gnt1 never asserted.
REQ-033 Tie after reset: req0=req1=1 on the first cycle -> gnt0 first; port 0 holds for 9 grants, then gnt1 on the 10th cycle with no gap.
REQ-034 Burst expiry without contention: req0=1 for 20 cycles -> 20 consecutive gnt0, cnt wraps 9->1, gray_req continuously 1.
REQ-035 Early release: port 0 drops req after 4 grants while req1=1 -> gnt1 on the very next cycle; rdata1 equals memory[addr1] with rvalid1 two cycles later.
REQ-036 Reset (reset=0) asserted one cycle after gnt1 -> rvalid1 stays 0, busy=0, state IDLE; after release, a tie grants port 0.
REQ-037 Random req/addr on both ports with a scoreboard -> every grant is returned exactly once, in order, to the correct port with the correct data.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared sizing and FSM encoding for the gray-image read arbiter.
package lbp_pkg;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 9;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    function automatic state_t own_of(input logic port);
        return port ? OWN1 : OWN0;
    endfunction
endpackage

// File: rtl/gray_rd_arb_if.sv
// Two read clients plus the single-ported gray memory, as seen by the arbiter.
interface gray_rd_arb_if;
    import lbp_pkg::*;

    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              gnt0, gnt1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              rvalid0, rvalid1;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              busy;

    modport slave (
        input  req0, addr0, req1, addr1, gray_data,
        output gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1,
               gray_req, gray_addr, busy
    );

    modport master (
        output req0, addr0, req1, addr1, gray_data,
        input  gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1,
               gray_req, gray_addr, busy
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin choice: a tie goes to the port that was not granted last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic pick
);
    assign valid = req0 | req1;
    assign pick  = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/gray_rd_arb.sv
// Burst-owning round-robin arbiter sharing one gray-image read port between two
// clients; 2-cycle grant-to-data latency, one read per cycle sustained.
module gray_rd_arb
    import lbp_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    gray_rd_arb_if.slave  bus
);
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              last;
    logic              gnt, gnt_port;
    logic              pick_vld, pick;
    logic              own, req_own, req_oth;
    logic [ADDR_W-1:0] gray_addr_q;
    // index 1: memory strobe issued, index 2: data returning to the client
    logic [2:1]        vld_pipe;
    logic [2:1]        tag_pipe;

    rr_pick2 u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last),
        .valid (pick_vld),
        .pick  (pick)
    );

    assign own     = (state == OWN1);
    assign req_own = own ? bus.req1 : bus.req0;
    assign req_oth = own ? bus.req0 : bus.req1;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gnt      = 1'b0;
        gnt_port = last;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt      = 1'b1;
                    gnt_port = pick;
                end
            end
            default: begin
                if (req_own && cnt < CNT_W'(BURST_MAX)) begin
                    gnt      = 1'b1;
                    gnt_port = own;
                end else if (req_oth) begin
                    gnt      = 1'b1;
                    gnt_port = ~own;
                end else if (req_own) begin
                    gnt      = 1'b1;
                    gnt_port = own;
                end
            end
        endcase
        // Handover to the other port happens in the same cycle, so no bubble.
        if (gnt) begin
            state_n = own_of(gnt_port);
            cnt_n   = (state == own_of(gnt_port) && cnt < CNT_W'(BURST_MAX))
                      ? cnt + CNT_W'(1) : CNT_W'(1);
        end else if (state != IDLE) begin
            state_n = IDLE;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 1'b1;
            bus.busy    <= 1'b0;
            gray_addr_q <= '0;
            vld_pipe    <= '0;
            tag_pipe    <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bus.busy    <= (state_n != IDLE);
            vld_pipe[1] <= gnt;
            vld_pipe[2] <= vld_pipe[1];
            tag_pipe[2] <= tag_pipe[1];
            if (gnt) begin
                last        <= gnt_port;
                tag_pipe[1] <= gnt_port;
                gray_addr_q <= gnt_port ? bus.addr1 : bus.addr0;
            end
        end
    end

    assign bus.gnt0      = reset & gnt & ~gnt_port;
    assign bus.gnt1      = reset & gnt &  gnt_port;
    assign bus.gray_req  = vld_pipe[1];
    assign bus.gray_addr = gray_addr_q;
    assign bus.rvalid0   = vld_pipe[2] & ~tag_pipe[2];
    assign bus.rvalid1   = vld_pipe[2] &  tag_pipe[2];
    assign bus.rdata0    = bus.gray_data;
    assign bus.rdata1    = bus.gray_data;
endmodule

// File: tb/tb_gray_rd_arb.sv
// Bench for gray_rd_arb: directed vector table, hand sequences, and random
// traffic scored against a rule-level arbitration model with a return queue.
module tb_gray_rd_arb;
    import lbp_pkg::*;

    typedef struct {
        bit r0, r1;
        bit g0, g1;
    } vec_t;

    typedef struct {
        int                due;
        bit                port;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gray_rd_arb_if bus ();

    gray_rd_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (bus.gray_req) bus.gray_data <= mem[bus.gray_addr];

    int tests = 0, fails = 0, cyc = 0;

    // reference model: owner (-1 idle), grants in current burst, last winner
    int                m_own  = -1;
    int                m_cnt  = 0;
    int                m_last = 1;
    int                m_prev = -1;
    logic [ADDR_W-1:0] m_gaddr = '0;
    ret_t              q[$];
    logic              s_gnt0, s_gnt1, s_greq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int exp_grant(input bit r0, input bit r1);
        bit r[2];
        r[0] = r0;
        r[1] = r1;
        if (m_own < 0) begin
            if (r0 && r1) return 1 - m_last;
            if (r0) return 0;
            if (r1) return 1;
            return -1;
        end
        if (r[m_own] && m_cnt < BURST_MAX) return m_own;
        if (r[1-m_own]) return 1 - m_own;
        if (r[m_own]) return m_own;
        return -1;
    endfunction

    // Called at posedge+1: drive, check at negedge, advance model, return at next posedge+1.
    task automatic step(input bit r0, input bit r1, input logic [ADDR_W-1:0] a0,
                        input logic [ADDR_W-1:0] a1);
        int         g;
        ret_t       e;
        logic [1:0] exp_v;
        bus.req0  = r0;
        bus.req1  = r1;
        bus.addr0 = a0;
        bus.addr1 = a1;
        @(negedge clk);
        g      = exp_grant(r0, r1);
        s_gnt0 = bus.gnt0;
        s_gnt1 = bus.gnt1;
        s_greq = bus.gray_req;
        chk("gnt", 32'({bus.gnt1, bus.gnt0}), 32'({g == 1, g == 0}));
        chk("gray_req", 32'(bus.gray_req), 32'(m_prev >= 0));
        chk("gray_addr", 32'(bus.gray_addr), 32'(m_gaddr));
        chk("busy", 32'(bus.busy), 32'(m_own >= 0));
        exp_v = 2'b00;
        if (q.size() > 0 && q[0].due == cyc) begin
            e     = q.pop_front();
            exp_v = e.port ? 2'b10 : 2'b01;
            chk("rdata", 32'(e.port ? bus.rdata1 : bus.rdata0), 32'(e.data));
        end
        chk("rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'(exp_v));
        if (g >= 0) begin
            q.push_back(ret_t'{cyc + 2, g[0], mem[g[0] ? a1 : a0]});
            m_gaddr = g[0] ? a1 : a0;
            m_cnt   = (m_own == g && m_cnt < BURST_MAX) ? m_cnt + 1 : 1;
            m_own   = g;
            m_last  = g;
        end else begin
            m_own = -1;
        end
        m_prev = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b0;
        q.delete();
        m_own    = -1;
        m_cnt    = 0;
        m_last   = 1;
        m_prev   = -1;
        m_gaddr  = '0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        repeat (n) begin
            @(negedge clk);
            chk("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
            chk("rst_out", 32'({bus.rvalid1, bus.rvalid0, bus.gray_req, bus.busy}), 32'd0);
            chk("rst_addr", 32'(bus.gray_addr), 32'd0);
            cyc++;
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        vec_t              tbl [17];
        bit                h0, h1, r0, r1;
        logic [ADDR_W-1:0] a0, a1;
        int                n0, n1;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;

        // tie after reset, 9-grant burst, handover, early release, idle, re-own
        for (int i = 0; i < 9; i++) tbl[i] = vec_t'{1, 1, 1, 0};
        for (int i = 9; i < 13; i++) tbl[i] = vec_t'{1, 1, 0, 1};
        tbl[13] = vec_t'{1, 0, 1, 0};
        tbl[14] = vec_t'{0, 0, 0, 0};
        tbl[15] = vec_t'{0, 1, 0, 1};
        tbl[16] = vec_t'{1, 1, 0, 1};

        @(posedge clk);
        #1;
        do_reset(3);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r0, tbl[i].r1, ADDR_W'(129), ADDR_W'(5000));
            chk("tbl_gnt", 32'({s_gnt0, s_gnt1}), 32'({tbl[i].g0, tbl[i].g1}));
        end
        repeat (3) step(0, 0, '0, '0);

        // single port, fixed address
        do_reset(2);
        n0 = 0; n1 = 0;
        repeat (3) begin
            step(1, 0, ADDR_W'(129), '0);
            n0 += int'(s_gnt0);
            n1 += int'(s_gnt1);
        end
        step(0, 0, '0, '0);
        chk("single_gnt0", 32'(n0), 32'd3);
        chk("single_gnt1", 32'(n1), 32'd0);
        chk("single_gaddr", 32'(bus.gray_addr), 32'd129);
        repeat (2) step(0, 0, '0, '0);

        // uncontended burst expiry keeps the read stream gap-free
        n0 = 0; n1 = 0;
        repeat (20) begin
            step(1, 0, ADDR_W'(300), '0);
            n0 += int'(s_gnt0);
            n1 += int'(s_greq);
        end
        chk("burst_gnt0", 32'(n0), 32'd20);
        chk("burst_greq", 32'(n1), 32'd19);
        repeat (3) step(0, 0, '0, '0);

        // reset while a port-1 read is in flight
        step(0, 1, '0, ADDR_W'(777));
        chk("pre_rst_gnt1", 32'(s_gnt1), 32'd1);
        do_reset(2);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        n1 = 0;
        repeat (3) begin
            step(0, 0, '0, '0);
            n1 += int'(bus.rvalid1);
        end
        chk("post_rst_rvalid1", 32'(n1), 32'd0);
        step(1, 1, ADDR_W'(11), ADDR_W'(22));
        chk("post_rst_tie", 32'({s_gnt0, s_gnt1}), 32'b10);
        repeat (3) step(0, 0, '0, '0);

        // random traffic; a pending (ungranted) request keeps its address
        h0 = 0; h1 = 0; r0 = 0; r1 = 0; a0 = '0; a1 = '0;
        repeat (600) begin
            if (!h0) begin
                r0 = ($urandom_range(0, 3) != 0);
                a0 = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            end
            if (!h1) begin
                r1 = ($urandom_range(0, 3) != 0);
                a1 = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            end
            step(r0, r1, a0, a1);
            h0 = r0 && !s_gnt0;
            h1 = r1 && !s_gnt1;
        end
        repeat (4) step(0, 0, '0, '0);
        chk("drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
